// File: rtl/coffee_ctrl_pkg.sv
// Shared definitions for the coffee-machine controller.
// Holds the state encoding, the price and coin values, and the selector codes
// that tell the datapath adder whether to add one or two units.
package coffee_ctrl_pkg;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD   = 3'd1;
   localparam logic [2:0] S_CHECK  = 3'd2;
   localparam logic [2:0] S_CHANGE = 3'd3;
   localparam logic [2:0] S_BREW   = 3'd4;
   localparam logic [2:0] S_CLEAR  = 3'd5;
   localparam logic [2:0] S_REFUND = 3'd6;

   typedef enum logic [2:0] {
      ST_IDLE   = S_IDLE,
      ST_LOAD   = S_LOAD,
      ST_CHECK  = S_CHECK,
      ST_CHANGE = S_CHANGE,
      ST_BREW   = S_BREW,
      ST_CLEAR  = S_CLEAR,
      ST_REFUND = S_REFUND
   } state_t;

   localparam logic [2:0] PRICE = 3'd3;
   localparam logic [2:0] COIN1 = 3'd1;
   localparam logic [2:0] COIN2 = 3'd2;

   localparam logic SEL_ADD1 = 1'b0;
   localparam logic SEL_ADD2 = 1'b1;

   // Credit added by the datapath for a given selector choice.
   function automatic logic [2:0] coin_value(input logic sel);
      return (sel == SEL_ADD2) ? COIN2 : COIN1;
   endfunction

endpackage

// File: rtl/coffee_ctrl_brew_timer.sv
// Brew-length down-counter.
// start  : loads BREW_CYCLES; the count then runs down to zero.
// done   : high in the last cycle of the brew (count == 1).
// clk_sys / rst_b : controller clock and asynchronous active-low reset.
module coffee_ctrl_brew_timer #(
   parameter int unsigned BREW_CYCLES = 8,
   parameter int unsigned TMR_W       = 4
) (
   input  logic clk_sys,
   input  logic rst_b,
   input  logic start,
   output logic done
);

   logic [TMR_W-1:0] cnt;

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         cnt <= '0;
      end else if (start) begin
         cnt <= TMR_W'(BREW_CYCLES);
      end else if (cnt != '0) begin
         cnt <= cnt - TMR_W'(1);
      end
   end

   assign done = (cnt == TMR_W'(1));

endmodule

// File: rtl/coffee_ctrl.sv
// Coffee-machine control unit.
// Drives the credit datapath (selector, adder, counter) from the coin and
// cancel pulses, reads back the 3-unit comparator flags and sequences
// dispensing, change and refunds. All outputs are registered.
// Inputs : clock, rst_n, coin_1, coin_2, cancel, less_3, eql_3, grt_3
// Outputs: sel_en, sel_sel, cnt_ld, cnt_en, cnt_ud, coffee_out, change,
//          coin_reject, busy
//
// state  | meaning
// IDLE   | waiting for a coin or cancel
// LOAD   | datapath adds the selected coin value to the credit
// CHECK  | comparator flags decide: wait, brew, or pay change first
// CHANGE | return one unit per cycle until credit equals the price
// BREW   | valve open for BREW_CYCLES cycles
// CLEAR  | consume the price: three down-counts, no change
// REFUND | return one unit per cycle until credit is zero
module coffee_ctrl
   import coffee_ctrl_pkg::*;
#(
   parameter int unsigned BREW_CYCLES = 8,
   parameter int unsigned TMR_W       = 4
) (
   input  logic Coffee_ctrl_clock,
   input  logic Coffee_ctrl_rst_n,
   input  logic Coffee_ctrl_coin_1,
   input  logic Coffee_ctrl_coin_2,
   input  logic Coffee_ctrl_cancel,
   input  logic Coffee_ctrl_less_3,
   input  logic Coffee_ctrl_eql_3,
   input  logic Coffee_ctrl_grt_3,
   output logic Coffee_ctrl_sel_en,
   output logic Coffee_ctrl_sel_sel,
   output logic Coffee_ctrl_cnt_ld,
   output logic Coffee_ctrl_cnt_en,
   output logic Coffee_ctrl_cnt_ud,
   output logic Coffee_ctrl_coffee_out,
   output logic Coffee_ctrl_change,
   output logic Coffee_ctrl_coin_reject,
   output logic Coffee_ctrl_busy
);

   state_t     state;
   logic [2:0] shadow;      // mirror of the datapath credit counter
   logic [2:0] flags;
   logic       any_coin;
   logic       tmr_start;
   logic       tmr_done;

   assign flags    = {Coffee_ctrl_less_3, Coffee_ctrl_eql_3, Coffee_ctrl_grt_3};
   assign any_coin = Coffee_ctrl_coin_1 | Coffee_ctrl_coin_2;

   // Timer is loaded on the edge that enters BREW, so it reads BREW_CYCLES
   // in the first brew cycle and 1 in the last.
   assign tmr_start = ((state == ST_CHECK)  && (flags == 3'b010)) ||
                      ((state == ST_CHANGE) && (shadow == PRICE + 3'd1));

   coffee_ctrl_brew_timer #(
      .BREW_CYCLES (BREW_CYCLES),
      .TMR_W       (TMR_W)
   ) u_brew_timer (
      .clk_sys (Coffee_ctrl_clock),
      .rst_b   (Coffee_ctrl_rst_n),
      .start   (tmr_start),
      .done    (tmr_done)
   );

   // Outputs are set on the transition into the state they belong to.
   always_ff @(posedge Coffee_ctrl_clock or negedge Coffee_ctrl_rst_n) begin
      if (!Coffee_ctrl_rst_n) begin
         state                   <= ST_IDLE;
         shadow                  <= '0;
         Coffee_ctrl_sel_en      <= 1'b0;
         Coffee_ctrl_sel_sel     <= SEL_ADD1;
         Coffee_ctrl_cnt_ld      <= 1'b0;
         Coffee_ctrl_cnt_en      <= 1'b0;
         Coffee_ctrl_cnt_ud      <= 1'b0;
         Coffee_ctrl_coffee_out  <= 1'b0;
         Coffee_ctrl_change      <= 1'b0;
         Coffee_ctrl_coin_reject <= 1'b0;
         Coffee_ctrl_busy        <= 1'b0;
      end else begin
         Coffee_ctrl_sel_en      <= 1'b0;
         Coffee_ctrl_cnt_ld      <= 1'b0;
         Coffee_ctrl_cnt_en      <= 1'b0;
         Coffee_ctrl_cnt_ud      <= 1'b0;   // controller only ever counts down
         Coffee_ctrl_coffee_out  <= 1'b0;
         Coffee_ctrl_change      <= 1'b0;
         Coffee_ctrl_coin_reject <= (state != ST_IDLE) && any_coin;
         Coffee_ctrl_busy        <= 1'b1;

         case (state)
            ST_IDLE: begin
               if (Coffee_ctrl_cancel && (shadow != 3'd0)) begin
                  state                   <= ST_REFUND;
                  Coffee_ctrl_cnt_en      <= 1'b1;
                  Coffee_ctrl_change      <= 1'b1;
                  Coffee_ctrl_coin_reject <= any_coin;
               end else if (Coffee_ctrl_coin_1 && Coffee_ctrl_coin_2) begin
                  Coffee_ctrl_coin_reject <= 1'b1;
                  Coffee_ctrl_busy        <= 1'b0;
               end else if (any_coin) begin
                  state               <= ST_LOAD;
                  Coffee_ctrl_sel_sel <= Coffee_ctrl_coin_2 ? SEL_ADD2 : SEL_ADD1;
                  Coffee_ctrl_sel_en  <= 1'b1;
                  Coffee_ctrl_cnt_ld  <= 1'b1;
               end else begin
                  Coffee_ctrl_busy <= 1'b0;
               end
            end

            ST_LOAD: begin
               shadow <= shadow + coin_value(Coffee_ctrl_sel_sel);
               state  <= ST_CHECK;
            end

            ST_CHECK: begin
               case (flags)
                  3'b100: begin
                     state            <= ST_IDLE;
                     Coffee_ctrl_busy <= 1'b0;
                  end
                  3'b010: begin
                     state                  <= ST_BREW;
                     Coffee_ctrl_coffee_out <= 1'b1;
                  end
                  3'b001: begin
                     state              <= ST_CHANGE;
                     Coffee_ctrl_cnt_en <= 1'b1;
                     Coffee_ctrl_change <= 1'b1;
                  end
                  default: begin
                     // Inconsistent flags: hand back whatever is held.
                     if (shadow != 3'd0) begin
                        state              <= ST_REFUND;
                        Coffee_ctrl_cnt_en <= 1'b1;
                        Coffee_ctrl_change <= 1'b1;
                     end else begin
                        state            <= ST_IDLE;
                        Coffee_ctrl_busy <= 1'b0;
                     end
                  end
               endcase
            end

            ST_CHANGE: begin
               shadow <= shadow - 3'd1;
               if (shadow == PRICE + 3'd1) begin
                  state                  <= ST_BREW;
                  Coffee_ctrl_coffee_out <= 1'b1;
               end else begin
                  Coffee_ctrl_cnt_en <= 1'b1;
                  Coffee_ctrl_change <= 1'b1;
               end
            end

            ST_BREW: begin
               if (tmr_done) begin
                  state              <= ST_CLEAR;
                  Coffee_ctrl_cnt_en <= 1'b1;
               end else begin
                  Coffee_ctrl_coffee_out <= 1'b1;
               end
            end

            ST_CLEAR: begin
               shadow <= shadow - 3'd1;
               if (shadow == 3'd1) begin
                  state            <= ST_IDLE;
                  Coffee_ctrl_busy <= 1'b0;
               end else begin
                  Coffee_ctrl_cnt_en <= 1'b1;
               end
            end

            ST_REFUND: begin
               if (shadow <= 3'd1) begin
                  shadow           <= '0;
                  state            <= ST_IDLE;
                  Coffee_ctrl_busy <= 1'b0;
               end else begin
                  shadow             <= shadow - 3'd1;
                  Coffee_ctrl_cnt_en <= 1'b1;
                  Coffee_ctrl_change <= 1'b1;
               end
            end

            default: begin
               state            <= ST_IDLE;
               Coffee_ctrl_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
